stage_sequencer: RTL

//  Handshake-driven phase sequencer for the processing pipeline: MEM load -> PE -> 3x3 conv -> 2x2 pool -> display.

---
 rtl/stage_sequencer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/stage_sequencer.sv
// Handshake-driven phase sequencer: MEM -> PE -> CONV3 -> POOL2 -> DISPLAY, with a settle gap between stages.
// Optional per-stage watchdog enabled by defining STAGE_TIMEOUT_EN; all outputs registered.
module stage_sequencer #(
  parameter int SETTLE_CYC  = 2,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] stage_done,
  output logic [3:0] stage_en,
  output logic       disp_en,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_stage
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_GAP,
    S_DISP,
    S_ERR
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
`ifdef STAGE_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYC - 1);
`endif

  state_t           state;
  logic [1:0]       k;
  logic [CNT_W-1:0] cnt;

`ifndef STAGE_TIMEOUT_EN
  assign error     = 1'b0;
  assign err_stage = 2'b00;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      k         <= 2'd0;
      cnt       <= '0;
      stage_en  <= 4'b0000;
      disp_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef STAGE_TIMEOUT_EN
      error     <= 1'b0;
      err_stage <= 2'd0;
`endif
    end else if (abort) begin
      // abort overrides every other event in the same cycle
      state     <= S_IDLE;
      k         <= 2'd0;
      cnt       <= '0;
      stage_en  <= 4'b0000;
      disp_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef STAGE_TIMEOUT_EN
      error     <= 1'b0;
      err_stage <= 2'd0;
`endif
    end else begin
      if (cnt != '1) cnt <= cnt + CNT_ONE;
      case (state)
        S_IDLE, S_DISP: begin
          if (start) begin
            state    <= S_RUN;
            k        <= 2'd0;
            cnt      <= '0;
            stage_en <= 4'b0001;
            busy     <= 1'b1;
            disp_en  <= 1'b0;
            done     <= 1'b0;
          end
        end
        S_RUN: begin
          if (stage_done[k]) begin
            cnt      <= '0;
            stage_en <= 4'b0000;
            if (k == 2'd3) begin
              state   <= S_DISP;
              busy    <= 1'b0;
              disp_en <= 1'b1;
              done    <= 1'b1;
            end else begin
              state <= S_GAP;
            end
          end
`ifdef STAGE_TIMEOUT_EN
          else if (cnt == TO_LAST) begin
            state     <= S_ERR;
            cnt       <= '0;
            stage_en  <= 4'b0000;
            busy      <= 1'b0;
            error     <= 1'b1;
            err_stage <= k;
          end
`endif
        end
        S_GAP: begin
          if (cnt == SETTLE_LAST) begin
            state    <= S_RUN;
            k        <= k + 2'd1;
            cnt      <= '0;
            stage_en <= 4'b0001 << (k + 2'd1);
          end
        end
        S_ERR: ;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
